// File: rtl/song_player.sv
// Auto-play melody sequencer: walks a 4-song note ROM and drives the buzzer, LEDs and song index.
// Each note is FETCH (1 cycle), PLAY, then a silent GAP; pause freezes timing, enable=0 aborts.
module song_player #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pause,
    input  logic [1:0] song_select,
    output logic [3:0] note,
    output logic [1:0] octave_auto,
    output logic [6:0] led,
    output logic [3:0] song_num,
    output logic       playing,
    output logic       song_done
);

    localparam int         CNT_W    = $clog2(8 * BEAT_CYCLES + 1);
    localparam logic [3:0] NT_END   = 4'hF;
    localparam logic [7:0] TERM     = {2'd0, NT_END, 2'd0};
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;

    state_t           state;
    logic [5:0]       addr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       select_prev;
    logic [3:0]       cur_nt;

    logic       next_edge;
    logic       prev_edge;
    logic       song_change;
    logic [1:0] next_song;
    logic [7:0] entry;

    // Entry layout {oct[1:0], nt[3:0], dur[1:0]}; a note lasts (1<<dur) beats.
    function automatic logic [7:0] rom_entry(input logic [1:0] song, input logic [5:0] idx);
        case (song)
            2'd0: begin
                case (idx)
                    6'd0:    rom_entry = {2'd1, 4'd1, 2'd0};
                    6'd1:    rom_entry = {2'd1, 4'd1, 2'd0};
                    6'd2:    rom_entry = {2'd1, 4'd5, 2'd0};
                    6'd3:    rom_entry = {2'd1, 4'd5, 2'd0};
                    6'd4:    rom_entry = {2'd1, 4'd6, 2'd0};
                    6'd5:    rom_entry = {2'd1, 4'd6, 2'd0};
                    6'd6:    rom_entry = {2'd1, 4'd5, 2'd1};
                    6'd7:    rom_entry = {2'd1, 4'd4, 2'd0};
                    6'd8:    rom_entry = {2'd1, 4'd4, 2'd0};
                    6'd9:    rom_entry = {2'd1, 4'd3, 2'd0};
                    6'd10:   rom_entry = {2'd1, 4'd3, 2'd0};
                    6'd11:   rom_entry = {2'd1, 4'd2, 2'd0};
                    6'd12:   rom_entry = {2'd1, 4'd2, 2'd0};
                    6'd13:   rom_entry = {2'd1, 4'd1, 2'd1};
                    default: rom_entry = TERM;
                endcase
            end
            2'd1: begin
                case (idx)
                    6'd0:    rom_entry = {2'd2, 4'd3, 2'd1};
                    6'd1:    rom_entry = {2'd2, 4'd0, 2'd0};
                    6'd2:    rom_entry = {2'd2, 4'd5, 2'd2};
                    6'd3:    rom_entry = {2'd1, 4'd7, 2'd0};
                    6'd4:    rom_entry = {2'd2, 4'd1, 2'd3};
                    default: rom_entry = TERM;
                endcase
            end
            // Song 2 fills all 64 slots with a rising scale, so it ends by address exhaustion.
            2'd2: rom_entry = {idx[5:4], 4'(idx % 6'd7) + 4'd1, 2'd0};
            default: begin
                case (idx)
                    6'd0:    rom_entry = {2'd1, 4'd1, 2'd0};
                    6'd1:    rom_entry = {2'd2, 4'd7, 2'd1};
                    default: rom_entry = TERM;
                endcase
            end
        endcase
    endfunction

    function automatic logic [6:0] one_hot(input logic [3:0] n);
        if (n >= 4'd1 && n <= 4'd7) one_hot = 7'd1 << (n - 4'd1);
        else                        one_hot = 7'd0;
    endfunction

    // PLAY counts down to zero, so it is loaded with its length minus one.
    function automatic logic [CNT_W-1:0] play_last(input logic [1:0] dur);
        case (dur)
            2'd0:    play_last = CNT_W'(BEAT_CYCLES - GAP_CYCLES - 1);
            2'd1:    play_last = CNT_W'(2 * BEAT_CYCLES - GAP_CYCLES - 1);
            2'd2:    play_last = CNT_W'(4 * BEAT_CYCLES - GAP_CYCLES - 1);
            default: play_last = CNT_W'(8 * BEAT_CYCLES - GAP_CYCLES - 1);
        endcase
    endfunction

    assign next_edge   = song_select[0] & ~select_prev[0];
    assign prev_edge   = song_select[1] & ~select_prev[1];
    assign song_change = next_edge ^ prev_edge;
    assign next_song   = next_edge ? song_num[1:0] + 2'd1 : song_num[1:0] + 2'd3;
    assign entry       = rom_entry(song_num[1:0], addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= 6'd0;
            cnt         <= '0;
            select_prev <= 2'b00;
            cur_nt      <= 4'd0;
            note        <= 4'd0;
            octave_auto <= 2'd0;
            led         <= 7'd0;
            song_num    <= 4'd0;
            playing     <= 1'b0;
            song_done   <= 1'b0;
        end else begin
            select_prev <= song_select;
            song_done   <= 1'b0;
            if (song_change) song_num <= {2'b00, next_song};

            if (!enable) begin
                state   <= IDLE;
                addr    <= 6'd0;
                cnt     <= '0;
                note    <= 4'd0;
                led     <= 7'd0;
                playing <= 1'b0;
            end else if (song_change || state == IDLE) begin
                // Start (or restart) at the first entry; song_num is already the new one next cycle.
                state   <= FETCH;
                addr    <= 6'd0;
                cnt     <= '0;
                note    <= 4'd0;
                led     <= 7'd0;
                playing <= 1'b1;
            end else begin
                case (state)
                    FETCH: begin
                        if (entry[5:2] == NT_END) begin
                            state     <= DONE;
                            playing   <= 1'b0;
                            song_done <= 1'b1;
                        end else begin
                            state       <= PLAY;
                            cur_nt      <= entry[5:2];
                            note        <= entry[5:2];
                            octave_auto <= entry[7:6];
                            led         <= one_hot(entry[5:2]);
                            cnt         <= play_last(entry[1:0]);
                        end
                    end
                    PLAY: begin
                        if (pause) begin
                            note <= 4'd0;
                            led  <= 7'd0;
                        end else if (cnt == '0) begin
                            state <= GAP;
                            cnt   <= GAP_LAST;
                            note  <= 4'd0;
                            led   <= 7'd0;
                        end else begin
                            cnt  <= cnt - 1'b1;
                            note <= cur_nt;
                            led  <= one_hot(cur_nt);
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end else if (addr == 6'd63) begin
                                state     <= DONE;
                                playing   <= 1'b0;
                                song_done <= 1'b1;
                            end else begin
                                state <= FETCH;
                                addr  <= addr + 6'd1;
                            end
                        end
                    end
                    DONE: begin
                        note    <= 4'd0;
                        led     <= 7'd0;
                        playing <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: directed scenarios plus randomized playback with random pauses,
// checked against a per-cycle timeline expanded from the song tables.
module tb_song_player;

    localparam int BEAT = 8;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pause;
    logic [1:0] song_select;
    logic [3:0] note;
    logic [1:0] octave_auto;
    logic [6:0] led;
    logic [3:0] song_num;
    logic       playing;
    logic       song_done;

    logic [16:0] obs;
    assign obs = {song_num, note, led, playing, song_done};

    song_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause),
        .song_select(song_select), .note(note), .octave_auto(octave_auto),
        .led(led), .song_num(song_num), .playing(playing), .song_done(song_done)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_song = 0;

    int song0_nt[14]  = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
    int song0_dur[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    int song1_oct[5]  = '{2, 2, 2, 1, 2};
    int song1_nt[5]   = '{3, 0, 5, 7, 1};
    int song1_dur[5]  = '{1, 0, 2, 0, 3};

    typedef struct {
        int phase;  // 0 fetch, 1 play, 2 gap
        int nt;
        int oct;
    } ev_t;
    ev_t tl[$];

    function automatic logic [6:0] led_of(input int n);
        return (n >= 1 && n <= 7) ? 7'(1 << (n - 1)) : 7'd0;
    endfunction

    function automatic logic [16:0] pack(input int s, input int n, input bit pl, input bit dn);
        return {4'(s), 4'(n), led_of(n), pl, dn};
    endfunction

    task automatic get_entry(input int s, input int a, output int oct, output int nt, output int dur);
        oct = 0; nt = 15; dur = 0;
        case (s)
            0: if (a < 14) begin oct = 1; nt = song0_nt[a]; dur = song0_dur[a]; end
            1: if (a < 5) begin oct = song1_oct[a]; nt = song1_nt[a]; dur = song1_dur[a]; end
            2: begin oct = a / 16; nt = a % 7 + 1; dur = 0; end
            default: begin
                if (a == 0) begin oct = 1; nt = 1; dur = 0; end
                else if (a == 1) begin oct = 2; nt = 7; dur = 1; end
            end
        endcase
    endtask

    // One element per clock interval from the first FETCH up to (not including) DONE.
    task automatic build_timeline(input int s);
        int oct, nt, dur;
        ev_t e;
        tl.delete();
        for (int a = 0; a < 64; a++) begin
            get_entry(s, a, oct, nt, dur);
            e.phase = 0; e.nt = 0; e.oct = oct;
            tl.push_back(e);
            if (nt == 15) break;
            for (int k = 0; k < (BEAT << dur) - GAP; k++) begin
                e.phase = 1; e.nt = nt; tl.push_back(e);
            end
            for (int k = 0; k < GAP; k++) begin
                e.phase = 2; e.nt = 0; tl.push_back(e);
            end
        end
    endtask

    task automatic press(input logic [1:0] v);
        song_select = v;
        @(negedge clk);
        song_select = 2'b00;
        @(negedge clk);
    endtask

    task automatic goto_song(input int s);
        while (model_song != s) begin
            press(2'b01);
            model_song = (model_song + 1) % 4;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        pause = 1'($urandom); song_select = 2'($urandom);
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({obs, octave_auto} !== 19'd0)
            $display("FAIL reset_hold: got %h want 0", {obs, octave_auto});
        else pass_cnt++;
        song_select = 2'b00; enable = 1'b0; pause = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({obs, octave_auto} !== 19'd0)
            $display("FAIL reset_idle: got %h want 0", {obs, octave_auto});
        else pass_cnt++;
        model_song = 0;
    endtask

    task automatic test_select();
        logic [1:0] v;
        press(2'b10); model_song = 3;
        total_cnt++;
        if (song_num !== 4'd3) $display("FAIL prev_from_0: got %0d want 3", song_num);
        else pass_cnt++;
        press(2'b01); model_song = 0;
        total_cnt++;
        if (song_num !== 4'd0) $display("FAIL next_from_3: got %0d want 0", song_num);
        else pass_cnt++;
        press(2'b11);
        total_cnt++;
        if (song_num !== 4'd0) $display("FAIL both_edges: got %0d want 0", song_num);
        else pass_cnt++;
        song_select = 2'b01;
        repeat (4) @(negedge clk);
        song_select = 2'b00;
        @(negedge clk);
        model_song = 1;
        total_cnt++;
        if (song_num !== 4'd1) $display("FAIL held_next: got %0d want 1", song_num);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            v = 2'($urandom_range(1, 3));
            press(v);
            if (v == 2'b01) model_song = (model_song + 1) % 4;
            else if (v == 2'b10) model_song = (model_song + 3) % 4;
            total_cnt++;
            if (song_num !== 4'(model_song))
                $display("FAIL rand_select %0d: got %0d want %0d", i, song_num, model_song);
            else pass_cnt++;
        end
    endtask

    task automatic test_song3();
        int dn, exp_note;
        logic [16:0] exp;
        goto_song(0);
        for (int i = 0; i < 3; i++) press(2'b01);
        model_song = 3;
        total_cnt++;
        if (song_num !== 4'd3) $display("FAIL three_nexts: got %0d want 3", song_num);
        else pass_cnt++;
        dn = 0;
        enable = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            exp_note = (i >= 1 && i <= 6) ? 1 : (i >= 10 && i <= 23) ? 7 : 0;
            exp = pack(3, exp_note, i <= 26, i == 27);
            if (song_done) dn++;
            total_cnt++;
            if (obs !== exp) $display("FAIL song3 cyc%0d: got %h want %h", i, obs, exp);
            else pass_cnt++;
            if (exp_note != 0) begin
                total_cnt++;
                if (octave_auto !== ((exp_note == 1) ? 2'd1 : 2'd2))
                    $display("FAIL song3_oct cyc%0d: got %0d", i, octave_auto);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (dn != 1) $display("FAIL song3_done_pulses: got %0d want 1", dn);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pause();
        int exp_note;
        goto_song(3);
        enable = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            @(negedge clk);
            exp_note = ((i >= 1 && i <= 3) || (i >= 9 && i <= 11)) ? 1 : (i == 15) ? 7 : 0;
            total_cnt++;
            if ({note, led, playing} !== {4'(exp_note), led_of(exp_note), 1'b1})
                $display("FAIL pause cyc%0d: got note=%0d led=%b play=%b want note=%0d",
                         i, note, led, playing, exp_note);
            else pass_cnt++;
            if (i >= 1 && i <= 11) begin
                total_cnt++;
                if (octave_auto !== 2'd1) $display("FAIL pause_oct cyc%0d: got %0d want 1", i, octave_auto);
                else pass_cnt++;
            end
            pause = (i >= 3 && i <= 7);
        end
        pause = 1'b0; enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_song_change();
        int dn;
        goto_song(3);
        enable = 1'b1;
        for (int i = 0; i <= 12; i++) @(negedge clk);
        total_cnt++;
        if (note !== 4'd7) $display("FAIL chg_pre: got note=%0d want 7", note);
        else pass_cnt++;
        song_select = 2'b01;
        @(negedge clk);
        song_select = 2'b00;
        model_song = 0;
        total_cnt++;
        if (obs !== pack(0, 0, 1'b1, 1'b0)) $display("FAIL chg_fetch: got %h want %h", obs, pack(0, 0, 1'b1, 1'b0));
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({obs, octave_auto} !== {pack(0, 1, 1'b1, 1'b0), 2'd1})
            $display("FAIL chg_first_note: got %h oct=%0d want note 1 oct 1", obs, octave_auto);
        else pass_cnt++;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (song_done) dn++;
        end
        total_cnt++;
        if (dn != 0) $display("FAIL chg_no_done: got %0d pulses want 0", dn);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        goto_song(3);
        enable = 1'b1;
        for (int i = 0; i <= 24; i++) @(negedge clk);
        total_cnt++;
        if ({note, playing} !== {4'd0, 1'b1}) $display("FAIL abort_in_gap: got note=%0d play=%b", note, playing);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs !== pack(3, 0, 1'b0, 1'b0)) $display("FAIL abort_idle: got %h want %h", obs, pack(3, 0, 1'b0, 1'b0));
        else pass_cnt++;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({obs, octave_auto} !== {pack(3, 1, 1'b1, 1'b0), 2'd1})
            $display("FAIL abort_restart: got %h oct=%0d want note 1 (addr 0)", obs, octave_auto);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1; pause = 1'b1; song_select = 2'b01;
        @(negedge clk);
        total_cnt++;
        if ({obs, octave_auto} !== 19'd0) $display("FAIL reset_mid_play: got %h want 0", {obs, octave_auto});
        else pass_cnt++;
        reset = 1'b0; pause = 1'b0; song_select = 2'b00; enable = 1'b0;
        model_song = 0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({obs, octave_auto} !== {pack(0, 1, 1'b1, 1'b0), 2'd1})
            $display("FAIL reset_restart: got %h oct=%0d want song0 note 1", obs, octave_auto);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_play();
        int s, idx;
        bit frozen, p;
        int shown;
        logic [16:0] exp;
        for (int it = 0; it < 6; it++) begin
            s = (it < 4) ? it : int'($urandom_range(3));
            goto_song(s);
            build_timeline(s);
            enable = 1'b1;
            idx = 0; frozen = 1'b0;
            while (idx < tl.size()) begin
                @(negedge clk);
                shown = frozen ? 0 : tl[idx].nt;
                exp = pack(s, shown, 1'b1, 1'b0);
                total_cnt++;
                if (obs !== exp) $display("FAIL play s%0d ev%0d: got %h want %h", s, idx, obs, exp);
                else pass_cnt++;
                if (tl[idx].phase == 1) begin
                    total_cnt++;
                    if (octave_auto !== 2'(tl[idx].oct))
                        $display("FAIL play_oct s%0d ev%0d: got %0d want %0d", s, idx, octave_auto, tl[idx].oct);
                    else pass_cnt++;
                end
                p = ($urandom_range(99) < 15);
                pause = p;
                if (p && tl[idx].phase != 0) frozen = 1'b1;
                else begin frozen = 1'b0; idx++; end
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                exp = pack(s, 0, 1'b0, k == 0);
                total_cnt++;
                if (obs !== exp) $display("FAIL done s%0d k%0d: got %h want %h", s, k, obs, exp);
                else pass_cnt++;
                pause = 1'($urandom);
            end
            pause = 1'b0; enable = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pause = 1'b0; song_select = 2'b00;
        test_reset();
        test_select();
        test_song3();
        test_pause();
        test_song_change();
        test_abort();
        test_random_play();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 The block SHALL have parameter BEAT_CYCLES, default 12_500_000, meaning clk cycles per beat (125 ms at 100 MHz).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1_250_000, meaning the silent articulation gap at the end of each note; the legal range is 1 <= GAP_CYCLES < BEAT_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: auto-play mode active (level).
REQ-006 The block SHALL have port pause, input, 1 bit: freeze playback (level).
REQ-007 The block SHALL have port song_select, input, 2 bits: bit0 is next-song button, bit1 is previous-song button (levels, already debounced).
REQ-008 The block SHALL have port note, output, 4 bits: 0 means rest, 1..7 means do..si; this feeds the buzzer note input.
REQ-009 The block SHALL have port octave_auto, output, 2 bits: octave of the current note, feeding the buzzer.
REQ-010 The block SHALL have port led, output, 7 bits: one-hot of the sounding note (bit n-1 for note n), or 0 when silent.
REQ-011 The block SHALL have port song_num, output, 4 bits: selected song index 0..3, feeding the seven-segment num input.
REQ-012 The block SHALL have port playing, output, 1 bit: high while in FETCH, PLAY or GAP.
REQ-013 The block SHALL have port song_done, output, 1 bit: one-cycle pulse at the end of a song.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 The internal ROM SHALL hold 4 songs of 64 entries each, addressed {song_num[1:0], addr[5:0]}.
REQ-016 Each ROM entry SHALL be 8 bits {oct[1:0], nt[3:0], dur[1:0]}, with a length of 1<<dur beats (1, 2, 4 or 8); nt = 4'hF marks the end of the song.
REQ-017 Song 3 SHALL be fixed as a test pattern: entry 0 = {1,1,0}, entry 1 = {2,7,1}, entry 2 = terminator.
REQ-018 The FSM SHALL have states IDLE, FETCH, PLAY, GAP and DONE.
REQ-019 In IDLE, when enable=1, the FSM SHALL go to FETCH with addr=0.
REQ-020 FETCH SHALL last 1 cycle and latch the entry: if nt=F, go to DONE; otherwise go to PLAY, driving note=nt, octave_auto=oct and led one-hot from the next cycle.
REQ-021 PLAY SHALL last exactly (1<<dur)*BEAT_CYCLES - GAP_CYCLES cycles, then go to GAP.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with note=0 and led=0, then go to FETCH with addr+1.
REQ-023 A note SHALL therefore occupy exactly (1<<dur)*BEAT_CYCLES + 1 cycles from FETCH to FETCH.
REQ-024 Address wrap: after the GAP of entry 63, the FSM SHALL go to DONE, not wrap to 0.
REQ-025 Entering DONE SHALL pulse song_done for exactly 1 cycle; in DONE, note=0, led=0 and playing=0, and the FSM holds until enable=0 or a song change.
REQ-026 pause=1 in PLAY or GAP SHALL freeze all counters and state, force note=0 and led=0, and leave octave_auto held.
REQ-027 Releasing pause SHALL resume with the remaining count intact.
REQ-028 pause SHALL be ignored in IDLE, FETCH and DONE.
REQ-029 enable=0 in any state SHALL move the FSM to IDLE on the next cycle with note=0, led=0 and playing=0; addr is not retained.
REQ-030 song_select SHALL use a rising-edge detect per bit (registered previous value).
REQ-031 A next edge SHALL set song_num to (song_num+1) mod 4; a prev edge SHALL set it to (song_num+3) mod 4.
REQ-032 Simultaneous next and prev edges in the same cycle SHALL be ignored.
REQ-033 A song change in FETCH, PLAY, GAP or DONE (with enable=1) SHALL restart at FETCH with addr=0 of the new song on the next cycle; in IDLE it only updates song_num.
REQ-034 The cycle counter SHALL be wide enough for 8*BEAT_CYCLES without overflow.

Reset
REQ-035 On reset=1 at a clk edge, the block SHALL set state=IDLE, addr=0, counters=0, note=0, octave_auto=0, led=0, song_num=0, playing=0, song_done=0, and edge registers=0.
REQ-036 Reset SHALL override enable, pause and song_select in the same cycle, including mid-note.

Verification (BEAT_CYCLES=8, GAP_CYCLES=2)
REQ-037 Reset -> all outputs 0; song_num=0; playing=0.
REQ-038 Pulse next 3 times in IDLE, then enable=1 -> song_num=3; after FETCH: note=1, octave_auto=1, led=7'b0000001 for 6 cycles, then note=0 for 2 cycles; then note=7, octave_auto=2, led=7'b1000000 for 14 cycles, then 2 gap cycles; song_done pulses once; playing=0.
REQ-039 Song 3 playing, pause=1 for 5 cycles mid-note 1 -> note=0 during the pause; after release, the remaining PLAY cycles are unchanged; total note span = 9+5 cycles.
REQ-040 Next and prev rising together -> song_num unchanged; prev from 0 -> 3; next from 3 -> 0.
REQ-041 Song change mid-PLAY -> the next cycle is FETCH addr 0 of the new song; song_done not pulsed.
REQ-042 enable dropped mid-GAP, and reset asserted mid-PLAY -> each returns to IDLE next cycle with note=0; re-enable restarts at addr 0.
